// File: rtl/nibble_distributor4_pkg.sv
// Shared constants and bank state encoding for the nibble distributor.
package nibble_distributor4_pkg;

  localparam int NLANES = 4;
  localparam int NIB_W  = 4;
  localparam int POS_W  = 3;
  localparam int NSLOTS = 2 ** POS_W;
  localparam int WORD_W = NIB_W * NSLOTS;

  localparam logic [NSLOTS-1:0] FULL_MASK = {NSLOTS{1'b1}};

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } bank_state_t;

endpackage

// File: rtl/nibble_bank.sv
// One word accumulator with fill mask, output register and FILL/HOLD state machine.
module nibble_bank
  import nibble_distributor4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NSLOTS-1:0] wr_mask,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              ready,
  output logic [WORD_W-1:0] data_out,
  output logic              valid,
  output logic [NSLOTS-1:0] mask,
  output bank_state_t       state
);

  logic [WORD_W-1:0] acc, acc_n, acc_m;
  logic [NSLOTS-1:0] mask_n, mask_m;
  logic [WORD_W-1:0] data_n;
  logic              valid_n;
  logic              pop;
  bank_state_t       state_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      acc      <= '0;
      mask     <= '0;
      data_out <= '0;
      valid    <= 1'b0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      mask     <= mask_n;
      data_out <= data_n;
      valid    <= valid_n;
    end
  end

  always_comb begin
    acc_m   = acc;
    mask_m  = mask | wr_mask;
    for (int i = 0; i < NSLOTS; i++) begin
      if (wr_mask[i]) acc_m[i*NIB_W +: NIB_W] = wr_data[i*NIB_W +: NIB_W];
    end
    pop     = valid && ready;
    state_n = state;
    acc_n   = acc;
    mask_n  = mask;
    data_n  = data_out;
    valid_n = valid;
    case (state)
      FILL: begin
        if (mask_m == FULL_MASK) begin
          if (!valid || ready) begin
            data_n  = acc_m;
            valid_n = 1'b1;
            acc_n   = '0;
            mask_n  = '0;
          end else begin
            // Output still occupied: freeze the finished word until it drains.
            state_n = HOLD;
            acc_n   = acc_m;
            mask_n  = mask_m;
          end
        end else begin
          acc_n  = acc_m;
          mask_n = mask_m;
          if (pop) valid_n = 1'b0;
        end
      end
      HOLD: begin
        if (pop) begin
          data_n  = acc;
          valid_n = 1'b1;
          acc_n   = '0;
          mask_n  = '0;
          state_n = FILL;
        end
      end
      default: state_n = FILL;
    endcase
  end

endmodule

// File: rtl/nibble_distributor4.sv
// Scatters four lane nibbles per beat into bank A / bank B word accumulators.
module nibble_distributor4
  import nibble_distributor4_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RESET_L,
  input  logic [NLANES*NIB_W-1:0] NIBBLE_IN,
  input  logic [NLANES*POS_W-1:0] pos_A,
  input  logic [NLANES*POS_W-1:0] pos_B,
  input  logic [NLANES-1:0]       SEL,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  output logic [WORD_W-1:0]       DATA_A_OUT,
  output logic                    VALID_A,
  input  logic                    READY_A,
  output logic [WORD_W-1:0]       DATA_B_OUT,
  output logic                    VALID_B,
  input  logic                    READY_B,
  output logic                    ERR_OVW,
  output bank_state_t             STATE_A,
  output bank_state_t             STATE_B
);

  // Handshake: a beat transfers when IN_VALID && IN_READY; an output word
  // transfers when VALID_X && READY_X. IN_READY depends only on bank state.
  logic              accept;
  logic [NSLOTS-1:0] wr_mask_a, wr_mask_b, mask_a, mask_b;
  logic [WORD_W-1:0] wr_data_a, wr_data_b;

  assign IN_READY = RESET_L && (STATE_A != HOLD) && (STATE_B != HOLD);
  assign accept   = IN_VALID && IN_READY;

  // Later lanes overwrite earlier ones, so the highest lane wins a collision.
  always_comb begin : route
    logic [POS_W-1:0] slot;
    wr_mask_a = '0;
    wr_mask_b = '0;
    wr_data_a = '0;
    wr_data_b = '0;
    slot      = '0;
    for (int k = 0; k < NLANES; k++) begin
      if (accept) begin
        if (!SEL[k]) begin
          slot = pos_A[k*POS_W +: POS_W];
          wr_mask_a[slot] = 1'b1;
          wr_data_a[slot*NIB_W +: NIB_W] = NIBBLE_IN[k*NIB_W +: NIB_W];
        end else begin
          slot = pos_B[k*POS_W +: POS_W];
          wr_mask_b[slot] = 1'b1;
          wr_data_b[slot*NIB_W +: NIB_W] = NIBBLE_IN[k*NIB_W +: NIB_W];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) ERR_OVW <= 1'b0;
    else          ERR_OVW <= (|(wr_mask_a & mask_a)) || (|(wr_mask_b & mask_b));
  end

  nibble_bank u_bank_a (
    .clk      (CLK),
    .rst_n    (RESET_L),
    .wr_mask  (wr_mask_a),
    .wr_data  (wr_data_a),
    .ready    (READY_A),
    .data_out (DATA_A_OUT),
    .valid    (VALID_A),
    .mask     (mask_a),
    .state    (STATE_A)
  );

  nibble_bank u_bank_b (
    .clk      (CLK),
    .rst_n    (RESET_L),
    .wr_mask  (wr_mask_b),
    .wr_data  (wr_data_b),
    .ready    (READY_B),
    .data_out (DATA_B_OUT),
    .valid    (VALID_B),
    .mask     (mask_b),
    .state    (STATE_B)
  );

endmodule

// File: tb/tb_nibble_distributor4.sv
// Bench for nibble_distributor4: vector table, directed corner sequences, random traffic vs model.
module tb_nibble_distributor4;
  import nibble_distributor4_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET_L = 1'b0;
  logic [15:0] NIBBLE_IN = '0;
  logic [11:0] pos_A = '0;
  logic [11:0] pos_B = '0;
  logic [3:0]  SEL = '0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] DATA_A_OUT, DATA_B_OUT;
  logic        VALID_A, VALID_B;
  logic        READY_A = 1'b0;
  logic        READY_B = 1'b0;
  logic        ERR_OVW;
  bank_state_t STATE_A, STATE_B;

  int n_checks = 0;
  int n_fail   = 0;

  nibble_distributor4 dut (
    .CLK        (CLK),
    .RESET_L    (RESET_L),
    .NIBBLE_IN  (NIBBLE_IN),
    .pos_A      (pos_A),
    .pos_B      (pos_B),
    .SEL        (SEL),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .DATA_A_OUT (DATA_A_OUT),
    .VALID_A    (VALID_A),
    .READY_A    (READY_A),
    .DATA_B_OUT (DATA_B_OUT),
    .VALID_B    (VALID_B),
    .READY_B    (READY_B),
    .ERR_OVW    (ERR_OVW),
    .STATE_A    (STATE_A),
    .STATE_B    (STATE_B)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  // Per bank: slot contents, which slots are filled, the presented word,
  // and a queue of finished words waiting for the output to drain.
  logic [3:0]  m_nib [2][8];
  bit          m_fill[2][8];
  logic [31:0] m_out [2];
  bit          m_val [2];
  bit          m_err;
  logic [31:0] held_a[$];
  logic [31:0] held_b[$];

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int s = 0; s < 8; s++) begin
        m_nib[b][s]  = '0;
        m_fill[b][s] = 1'b0;
      end
      m_out[b] = '0;
      m_val[b] = 1'b0;
    end
    m_err = 1'b0;
    held_a.delete();
    held_b.delete();
  endtask

  function automatic bit model_in_ready();
    return (held_a.size() == 0) && (held_b.size() == 0);
  endfunction

  task automatic model_step();
    bit          accept;
    bit          err;
    bit          pop;
    bit          all_full;
    int          slot;
    logic [31:0] word;
    accept = IN_VALID && model_in_ready();
    err    = 1'b0;
    for (int b = 0; b < 2; b++) begin
      pop = m_val[b] && ((b == 0) ? READY_A : READY_B);
      if ((b == 0 && held_a.size() > 0) || (b == 1 && held_b.size() > 0)) begin
        if (pop) m_out[b] = (b == 0) ? held_a.pop_front() : held_b.pop_front();
      end else begin
        if (accept) begin
          for (int k = 0; k < 4; k++)
            if (int'(SEL[k]) == b) begin
              slot = (b == 0) ? int'(pos_A[3*k +: 3]) : int'(pos_B[3*k +: 3]);
              if (m_fill[b][slot]) err = 1'b1;
            end
          for (int k = 0; k < 4; k++)
            if (int'(SEL[k]) == b) begin
              slot = (b == 0) ? int'(pos_A[3*k +: 3]) : int'(pos_B[3*k +: 3]);
              m_nib[b][slot]  = NIBBLE_IN[4*k +: 4];
              m_fill[b][slot] = 1'b1;
            end
        end
        all_full = 1'b1;
        for (int s = 0; s < 8; s++) if (!m_fill[b][s]) all_full = 1'b0;
        if (all_full) begin
          word = '0;
          for (int s = 0; s < 8; s++) begin
            word[4*s +: 4] = m_nib[b][s];
            m_fill[b][s]   = 1'b0;
          end
          if (!m_val[b] || pop) begin
            m_out[b] = word;
            m_val[b] = 1'b1;
          end else if (b == 0) held_a.push_back(word);
          else                 held_b.push_back(word);
        end else if (pop) begin
          m_val[b] = 1'b0;
        end
      end
    end
    m_err = err;
  endtask

  // ---------------- scoreboard helpers ----------------
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic check_model(string tag);
    chk({tag, ".data_a"},   DATA_A_OUT,      m_out[0]);
    chk({tag, ".valid_a"},  32'(VALID_A),    32'(m_val[0]));
    chk({tag, ".data_b"},   DATA_B_OUT,      m_out[1]);
    chk({tag, ".valid_b"},  32'(VALID_B),    32'(m_val[1]));
    chk({tag, ".err"},      32'(ERR_OVW),    32'(m_err));
    chk({tag, ".in_ready"}, 32'(IN_READY),   32'(RESET_L && model_in_ready()));
    chk({tag, ".state_a"},  32'(STATE_A),    32'((held_a.size() > 0) ? HOLD : FILL));
    chk({tag, ".state_b"},  32'(STATE_B),    32'((held_b.size() > 0) ? HOLD : FILL));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [15:0] nib, input logic [11:0] pa, input logic [11:0] pb,
                       input logic [3:0] sel, input logic v);
    NIBBLE_IN = nib;
    pos_A     = pa;
    pos_B     = pb;
    SEL       = sel;
    IN_VALID  = v;
  endtask

  task automatic cycle(string tag);
    @(posedge CLK);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, ".data_a"},   DATA_A_OUT,    32'h0);
    chk({tag, ".valid_a"},  32'(VALID_A),  32'h0);
    chk({tag, ".data_b"},   DATA_B_OUT,    32'h0);
    chk({tag, ".valid_b"},  32'(VALID_B),  32'h0);
    chk({tag, ".err"},      32'(ERR_OVW),  32'h0);
    chk({tag, ".in_ready"}, 32'(IN_READY), 32'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] nib;
    logic [11:0] pa;
    logic [11:0] pb;
    logic [3:0]  sel;
    logic        v;
    logic        ra;
    logic        rb;
    logic        exp_va;
    logic [31:0] exp_da;
    logic        exp_vb;
    logic [31:0] exp_db;
    logic        exp_err;
    logic        exp_rdy;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [15:0] rnib;
    logic [11:0] pa, pb;

    vecs[0] = '{16'h4321, 12'h688, 12'h000, 4'b0000, 1, 1, 1, 0, 32'h0,        0, 32'h0, 0, 1};
    vecs[1] = '{16'h8765, 12'hFAC, 12'h000, 4'b0000, 1, 1, 1, 1, 32'h87654321, 0, 32'h0, 0, 1};
    vecs[2] = '{16'h0000, 12'h000, 12'h000, 4'b0000, 0, 1, 1, 0, 32'h87654321, 0, 32'h0, 0, 1};
    vecs[3] = '{16'h2913, 12'h345, 12'h000, 4'b0000, 1, 1, 1, 0, 32'h87654321, 0, 32'h0, 0, 1};
    vecs[4] = '{16'hDCBA, 12'h8D5, 12'h000, 4'b0000, 1, 1, 1, 0, 32'h87654321, 0, 32'h0, 1, 1};
    vecs[5] = '{16'h65FE, 12'h03E, 12'h200, 4'b1100, 1, 1, 1, 1, 32'hFEADCB21, 0, 32'h0, 0, 1};
    vecs[6] = '{16'h0000, 12'h000, 12'h000, 4'b0000, 0, 1, 1, 0, 32'hFEADCB21, 0, 32'h0, 0, 1};

    // reset block
    model_reset();
    @(negedge CLK);
    check_reset_outputs("por");
    @(negedge CLK);
    RESET_L = 1'b1;
    @(negedge CLK);

    // table vectors
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].nib, vecs[i].pa, vecs[i].pb, vecs[i].sel, vecs[i].v);
      READY_A = vecs[i].ra;
      READY_B = vecs[i].rb;
      cycle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_va", i),  32'(VALID_A),  32'(vecs[i].exp_va));
      chk($sformatf("vec%0d.tbl_da", i),  DATA_A_OUT,    vecs[i].exp_da);
      chk($sformatf("vec%0d.tbl_vb", i),  32'(VALID_B),  32'(vecs[i].exp_vb));
      chk($sformatf("vec%0d.tbl_db", i),  DATA_B_OUT,    vecs[i].exp_db);
      chk($sformatf("vec%0d.tbl_err", i), 32'(ERR_OVW),  32'(vecs[i].exp_err));
      chk($sformatf("vec%0d.tbl_rdy", i), 32'(IN_READY), 32'(vecs[i].exp_rdy));
    end

    // Finish the partial B word with READY_B low, then half-fill A, then reset.
    READY_B = 1'b0;
    drive(16'h3A7C, 12'h000, {3'd5, 3'd4, 3'd3, 3'd2}, 4'b1111, 1);
    cycle("rst_pre0");
    drive(16'h1298, {3'd1, 3'd0, 3'd0, 3'd0}, {3'd0, 3'd0, 3'd7, 3'd6}, 4'b0011, 1);
    cycle("rst_pre1");
    drive(16'h5555, {3'd3, 3'd2, 3'd3, 3'd2}, 12'h000, 4'b0000, 1);
    cycle("rst_pre2");
    chk("rst_pre.valid_b", 32'(VALID_B), 32'h1);
    #2 RESET_L = 1'b0;
    #1 check_reset_outputs("mid_rst");
    model_reset();
    @(negedge CLK);
    RESET_L = 1'b1;
    READY_A = 1'b1;
    READY_B = 1'b1;
    drive(16'h4321, 12'h688, 12'h000, 4'b0000, 1);
    cycle("post_rst0");
    drive(16'h8765, 12'hFAC, 12'h000, 4'b0000, 1);
    cycle("post_rst1");
    chk("post_rst.word", DATA_A_OUT, 32'h87654321);

    // Dual completion: lanes 0,2 to A and lanes 1,3 to B over 4 beats.
    for (int j = 0; j < 4; j++) begin
      rnib = 16'($urandom);
      pa = '0;
      pb = '0;
      pa[2:0]  = 3'(2*j);
      pa[8:6]  = 3'(2*j + 1);
      pb[5:3]  = 3'(2*j);
      pb[11:9] = 3'(2*j + 1);
      drive(rnib, pa, pb, 4'b1010, 1);
      cycle($sformatf("dual%0d", j));
    end
    chk("dual.valid_a", 32'(VALID_A), 32'h1);
    chk("dual.valid_b", 32'(VALID_B), 32'h1);

    // Hold: second A word completes while the first is still unconsumed.
    drive(16'h0, 12'h0, 12'h0, 4'b0, 0);
    cycle("hold_drain");
    READY_A = 1'b0;
    drive(16'h4321, 12'h688, 12'h000, 4'b0000, 1);
    cycle("hold0");
    drive(16'h8765, 12'hFAC, 12'h000, 4'b0000, 1);
    cycle("hold1");
    drive(16'hCBA9, 12'h688, 12'h000, 4'b0000, 1);
    cycle("hold2");
    drive(16'h0FED, 12'hFAC, 12'h000, 4'b0000, 1);
    cycle("hold3");
    chk("hold.state_a",  32'(STATE_A),  32'(HOLD));
    chk("hold.in_ready", 32'(IN_READY), 32'h0);
    chk("hold.data_a",   DATA_A_OUT,    32'h87654321);
    drive(16'hFFFF, 12'h000, 12'h000, 4'b0000, 1);
    cycle("hold_blocked0");
    cycle("hold_blocked1");
    chk("hold_blocked.data_a", DATA_A_OUT, 32'h87654321);
    drive(16'h0, 12'h0, 12'h0, 4'b0, 0);
    READY_A = 1'b1;
    cycle("hold_release");
    chk("release.data_a",   DATA_A_OUT,    32'h0FEDCBA9);
    chk("release.valid_a",  32'(VALID_A),  32'h1);
    chk("release.in_ready", 32'(IN_READY), 32'h1);
    cycle("release_pop");

    // Idle: IN_VALID low with changing inputs must not disturb anything.
    READY_A = 1'b0;
    READY_B = 1'b0;
    drive(16'h1234, 12'h688, 12'h000, 4'b0000, 1);
    cycle("idle_seed");
    for (int j = 0; j < 10; j++) begin
      drive(16'($urandom), 12'($urandom), 12'($urandom), 4'($urandom), 0);
      cycle($sformatf("idle%0d", j));
    end

    // Random traffic against the model.
    for (int j = 0; j < 400; j++) begin
      drive(16'($urandom), 12'($urandom), 12'($urandom), 4'($urandom),
            1'($urandom_range(0, 3) != 0));
      READY_A = ($urandom_range(0, 3) != 0);
      READY_B = ($urandom_range(0, 3) != 0);
      cycle($sformatf("rnd%0d", j));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
